// File: rtl/adder_rr_sched_pkg.sv
// Shared types and default parameters for the round-robin adder scheduler.
package adder_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } sched_state_t;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_W       = 8;
   localparam int DEF_ADD_LAT = 1;

   // Width of a counter that must hold values up to n-1; never narrower than 1 bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/adder_rr_sched_if.sv
// Request, shared-adder and response signals of the scheduler bundled as one interface.
// The slave view belongs to the scheduler; the master view belongs to clients plus the adder.
interface adder_rr_sched_if
   import adder_sched_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int W       = DEF_W
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ*W-1:0] req_a;
   logic [NUM_REQ*W-1:0] req_b;
   logic [W-1:0]         add_a;
   logic [W-1:0]         add_b;
   logic [W:0]           add_sum;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [W:0]           rsp_sum;
   logic [IDW-1:0]       rsp_id;

   modport slave (
      input  req_valid, req_a, req_b, add_sum, rsp_ready,
      output req_ready, add_a, add_b, rsp_valid, rsp_sum, rsp_id
   );

   modport master (
      output req_valid, req_a, req_b, add_sum, rsp_ready,
      input  req_ready, add_a, add_b, rsp_valid, rsp_sum, rsp_id
   );

endinterface

// File: rtl/adder_rr_sched_rr_pick.sv
// Combinational round-robin picker: searches the request vector starting one
// position after the last grant, wrapping around, and returns the first hit.
module rr_pick
   import adder_sched_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDW-1:0]     i_last,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDW-1:0]     o_idx,
   output logic               o_any
);

   // Scan NUM_REQ positions after i_last; the first requester found wins.
   always_comb begin
      int  w_pos;
      logic w_found;
      // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_pos   = 0;
      w_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_pos = (int'(i_last) + k) % NUM_REQ;
         if (!w_found && i_req[w_pos]) begin
            o_grant[w_pos] = 1'b1;
            o_idx          = IDW'(w_pos);
            o_any          = 1'b1;
            w_found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler time-sharing one registered adder among NUM_REQ clients.
// One operation in flight: IDLE grants, ISSUE/WAIT cover adder latency, RESP
// holds the tagged result until the consumer takes it.
module adder_rr_sched
   import adder_sched_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int W       = DEF_W,
   parameter int ADD_LAT = DEF_ADD_LAT
) (
   input  logic             clk,
   input  logic             reset,
   adder_rr_sched_if.slave  bus
);

   localparam int IDW  = $clog2(NUM_REQ);
   localparam int CNTW = cnt_width(ADD_LAT);

   sched_state_t        r_state;
   sched_state_t        w_state_nxt;

   logic [NUM_REQ-1:0]  w_grant;
   logic [IDW-1:0]      w_grant_idx;
   logic                w_any;

   logic [NUM_REQ-1:0]  w_req_ready;
   logic                w_accept;
   logic                w_capture;
   logic                w_rsp_valid;
   logic                w_rsp_done;

   logic [W-1:0]        r_add_a;
   logic [W-1:0]        r_add_b;
   logic [W:0]          r_rsp_sum;
   logic [IDW-1:0]      r_rsp_id;
   logic [IDW-1:0]      r_last_grant;
   logic [CNTW-1:0]     r_cnt;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_pick (
      .i_req   (bus.req_valid),
      .i_last  (r_last_grant),
      .o_grant (w_grant),
      .o_idx   (w_grant_idx),
      .o_any   (w_any)
   );

   // State register; reset returns to IDLE and aborts any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode plus the handshake strobes derived from the current state.
   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = '0;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_rsp_valid = 1'b0;
      w_rsp_done  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_req_ready = w_grant;
               w_accept    = 1'b1;
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (r_cnt == '0) begin
               w_capture   = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            w_rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               w_rsp_done  = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Operand latch on grant, latency countdown, result capture and priority pointer update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: these are plain registers with visible reset values, not a memory array, so all are reset.
         r_add_a      <= '0;
         r_add_b      <= '0;
         r_rsp_sum    <= '0;
         r_rsp_id     <= '0;
         r_cnt        <= '0;
         r_last_grant <= IDW'(NUM_REQ - 1);
      end else begin
         if (w_accept) begin
            r_add_a  <= bus.req_a[w_grant_idx*W +: W];
            r_add_b  <= bus.req_b[w_grant_idx*W +: W];
            r_rsp_id <= w_grant_idx;
         end
         if (r_state == ISSUE) begin
            r_cnt <= CNTW'(ADD_LAT - 1);
         end else if (r_state == WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - CNTW'(1);
         end
         if (w_capture) begin
            r_rsp_sum <= bus.add_sum;
         end
         if (w_rsp_done) begin
            r_last_grant <= r_rsp_id;
         end
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.add_a     = r_add_a;
   assign bus.add_b     = r_add_b;
   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_sum   = r_rsp_sum;
   assign bus.rsp_id    = r_rsp_id;

endmodule
